// File: rtl/morse_playback_controller.sv
// Morse playback: snapshots the 16-slot sequence store on start and keys each valid slot
// out on `tone`, oldest slot (15) first, with symbol and letter gaps.
module morse_playback_controller #(
  parameter int unsigned UNIT_CYCLES      = 4,
  parameter int unsigned DASH_UNITS       = 3,
  parameter int unsigned LETTER_GAP_UNITS = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [159:0] store_seqs,
  output logic         tone,
  output logic         busy,
  output logic         done,
  output logic [3:0]   slot_idx
);

  localparam int unsigned MaxUnits = (DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS
                                                                     : LETTER_GAP_UNITS;
  localparam int unsigned CntMax   = MaxUnits * UNIT_CYCLES;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DotCnt  = CntW'(UNIT_CYCLES);
  localparam logic [CntW-1:0] DashCnt = CntW'(DASH_UNITS * UNIT_CYCLES);
  localparam logic [CntW-1:0] GapCnt  = CntW'(UNIT_CYCLES);
  localparam logic [CntW-1:0] LgapCnt = CntW'(LETTER_GAP_UNITS * UNIT_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [1:0] SymDot  = 2'b01;
  localparam logic [1:0] SymDash = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StToneOn,
    StSymGap,
    StLetterGap,
    StDone
  } state_e;

  state_e          state_q;
  logic [159:0]    snap_q;
  logic [2:0]      sym_ptr_q;
  logic [CntW-1:0] cnt_q;

  logic [9:0] cur_slot;
  logic [1:0] cur_sym;
  logic [1:0] next_sym;
  logic       next_is_tone;

  always_comb begin
    cur_slot = 10'h3FF;
    for (int k = 0; k < 16; k++) begin
      if (slot_idx == 4'(k)) cur_slot = snap_q[10*k +: 10];
    end
  end

  // Symbols are packed MSB pair first; pointer values past 4 read as end-of-letter.
  always_comb begin
    cur_sym  = 2'b00;
    next_sym = 2'b00;
    case (sym_ptr_q)
      3'd0: begin cur_sym = cur_slot[9:8]; next_sym = cur_slot[7:6]; end
      3'd1: begin cur_sym = cur_slot[7:6]; next_sym = cur_slot[5:4]; end
      3'd2: begin cur_sym = cur_slot[5:4]; next_sym = cur_slot[3:2]; end
      3'd3: begin cur_sym = cur_slot[3:2]; next_sym = cur_slot[1:0]; end
      3'd4: begin cur_sym = cur_slot[1:0]; next_sym = 2'b00;         end
      default: begin cur_sym = 2'b00;      next_sym = 2'b00;         end
    endcase
  end

  assign next_is_tone = (sym_ptr_q < 3'd4) && ((next_sym == SymDot) || (next_sym == SymDash));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      snap_q    <= '1;
      sym_ptr_q <= 3'd0;
      cnt_q     <= '0;
      tone      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      slot_idx  <= 4'hF;
    end else begin
      done <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q   <= StIdle;
        sym_ptr_q <= 3'd0;
        cnt_q     <= '0;
        tone      <= 1'b0;
        busy      <= 1'b0;
        slot_idx  <= 4'hF;
      end else begin
        case (state_q)
          StIdle: begin
            if (start && !abort) begin
              snap_q    <= store_seqs;
              slot_idx  <= 4'hF;
              sym_ptr_q <= 3'd0;
              busy      <= 1'b1;
              state_q   <= StFetch;
            end
          end
          StFetch: begin
            if (cur_slot[9:8] == 2'b11) begin
              if (slot_idx == 4'd0) begin
                done    <= 1'b1;
                state_q <= StDone;
              end else begin
                slot_idx <= slot_idx - 4'd1;
              end
            end else begin
              state_q <= StDecode;
            end
          end
          StDecode: begin
            if (cur_sym == SymDot) begin
              cnt_q   <= DotCnt;
              tone    <= 1'b1;
              state_q <= StToneOn;
            end else if (cur_sym == SymDash) begin
              cnt_q   <= DashCnt;
              tone    <= 1'b1;
              state_q <= StToneOn;
            end else begin
              cnt_q   <= LgapCnt;
              state_q <= StLetterGap;
            end
          end
          StToneOn: begin
            if (cnt_q == CntOne) begin
              tone <= 1'b0;
              if (next_is_tone) begin
                cnt_q   <= GapCnt;
                state_q <= StSymGap;
              end else begin
                cnt_q   <= LgapCnt;
                state_q <= StLetterGap;
              end
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
          StSymGap: begin
            if (cnt_q == CntOne) begin
              sym_ptr_q <= sym_ptr_q + 3'd1;
              state_q   <= StDecode;
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
          StLetterGap: begin
            if (cnt_q == CntOne) begin
              if (slot_idx == 4'd0) begin
                done    <= 1'b1;
                state_q <= StDone;
              end else begin
                slot_idx  <= slot_idx - 4'd1;
                sym_ptr_q <= 3'd0;
                state_q   <= StFetch;
              end
            end else begin
              cnt_q <= cnt_q - CntOne;
            end
          end
          StDone: begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_playback_controller.sv
// Directed bench for morse_playback_controller: records per-cycle outputs after each start
// and compares run positions, lengths and handshake timing with hand-derived values.
module tb_morse_playback_controller;

  localparam int MaxLen = 100;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         abort;
  logic [159:0] store_seqs;
  logic         tone;
  logic         busy;
  logic         done;
  logic [3:0]   slot_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int tr_len  = 0;

  logic       tr_tone [MaxLen];
  logic       tr_busy [MaxLen];
  logic       tr_done [MaxLen];
  logic [3:0] tr_slot [MaxLen];

  morse_playback_controller #(
    .UNIT_CYCLES      (4),
    .DASH_UNITS       (3),
    .LETTER_GAP_UNITS (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .store_seqs (store_seqs),
    .tone       (tone),
    .busy       (busy),
    .done       (done),
    .slot_idx   (slot_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Called 1 time unit after a rising edge. Index k holds outputs after the k-th edge
  // following the start request; the *_at arguments schedule drives for the next edge.
  task automatic play(input int n, input int abort_at, input int start_at, input int chg_at,
                      input logic [159:0] chg_val);
    start = 1'b1;
    tr_len = n;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      tr_tone[k] = tone;
      tr_busy[k] = busy;
      tr_done[k] = done;
      tr_slot[k] = slot_idx;
      start = (k == start_at);
      abort = (k == abort_at);
      if (k == chg_at) store_seqs = chg_val;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic int first_tone(input int from, input logic v);
    for (int i = from; i < tr_len; i++) if (tr_tone[i] == v) return i;
    return -1;
  endfunction

  function automatic int run_len(input int from);
    int len = 0;
    if (from < 0) return -1;
    for (int i = from; i < tr_len && tr_tone[i] == 1'b1; i++) len++;
    return len;
  endfunction

  function automatic int first_done();
    for (int i = 0; i < tr_len; i++) if (tr_done[i] == 1'b1) return i;
    return -1;
  endfunction

  function automatic int done_count();
    int c = 0;
    for (int i = 0; i < tr_len; i++) if (tr_done[i] == 1'b1) c++;
    return c;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [159:0] StBasic = {10'b01_10_00_00_00, {150{1'b1}}};
  localparam logic [159:0] StEmpty = {160{1'b1}};
  localparam logic [159:0] StTwo   = {10'b01_00_00_00_00, {140{1'b1}}, 10'b10_00_00_00_00};
  localparam logic [159:0] StDash2 = {10'b10_10_00_00_00, {150{1'b1}}};

  int h;

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    store_seqs = StEmpty;
    #12;
    check_eq("rst_tone", tone, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_slot", slot_idx, 15);
    reset_n = 1'b1;
    idle_cycles(2);
    check_eq("idle_busy", busy, 0);

    // Basic letter: dot, dash
    store_seqs = StBasic;
    play(60, -1, -1, -1, '0);
    h = first_tone(0, 1'b1);
    check_eq("basic_dot_start", h, 2);
    check_eq("basic_dot_len", run_len(h), 4);
    h = first_tone(6, 1'b1);
    check_eq("basic_dash_start", h, 11);
    check_eq("basic_dash_len", run_len(h), 12);
    check_eq("basic_no_more_tone", first_tone(23, 1'b1), -1);
    check_eq("basic_busy_first", tr_busy[0], 1);
    check_eq("basic_done_at", first_done(), 50);
    check_eq("basic_done_count", done_count(), 1);
    check_eq("basic_busy_at_done", tr_busy[50], 1);
    check_eq("basic_busy_after", tr_busy[51], 0);
    check_eq("basic_slot_skip", tr_slot[35], 14);
    idle_cycles(3);

    // All slots empty
    store_seqs = StEmpty;
    play(25, -1, -1, -1, '0);
    check_eq("empty_no_tone", first_tone(0, 1'b1), -1);
    check_eq("empty_done_at", first_done(), 16);
    check_eq("empty_slot0", tr_slot[0], 15);
    check_eq("empty_slot5", tr_slot[5], 10);
    check_eq("empty_slot15", tr_slot[15], 0);
    check_eq("empty_busy_after", tr_busy[17], 0);
    idle_cycles(3);

    // Two letters: slot15 dot, slot0 dash
    store_seqs = StTwo;
    play(65, -1, -1, -1, '0);
    h = first_tone(0, 1'b1);
    check_eq("two_dot_start", h, 2);
    check_eq("two_dot_len", run_len(h), 4);
    h = first_tone(6, 1'b1);
    check_eq("two_dash_start", h, 34);
    check_eq("two_dash_len", run_len(h), 12);
    check_eq("two_dash_slot", tr_slot[40], 0);
    check_eq("two_done_at", first_done(), 58);
    check_eq("two_done_count", done_count(), 1);
    idle_cycles(3);

    // Abort during the first dash
    store_seqs = StDash2;
    play(30, 5, -1, -1, '0);
    check_eq("abort_tone_before", tr_tone[5], 1);
    check_eq("abort_tone", tr_tone[6], 0);
    check_eq("abort_busy", tr_busy[6], 0);
    check_eq("abort_slot", tr_slot[6], 15);
    check_eq("abort_no_done", done_count(), 0);
    check_eq("abort_stays_idle", first_tone(6, 1'b1), -1);
    play(65, -1, -1, -1, '0);
    h = first_tone(0, 1'b1);
    check_eq("replay_dash_start", h, 2);
    check_eq("replay_dash_len", run_len(h), 12);
    check_eq("replay_dash2_start", first_tone(14, 1'b1), 19);
    check_eq("replay_done_at", first_done(), 58);
    idle_cycles(3);

    // Snapshot isolation and start ignored while busy
    store_seqs = StBasic;
    play(70, -1, 5, 3, '0);
    store_seqs = StBasic;
    h = first_tone(0, 1'b1);
    check_eq("snap_dot_start", h, 2);
    check_eq("snap_dot_len", run_len(h), 4);
    h = first_tone(6, 1'b1);
    check_eq("snap_dash_start", h, 11);
    check_eq("snap_dash_len", run_len(h), 12);
    check_eq("snap_no_more_tone", first_tone(23, 1'b1), -1);
    check_eq("snap_done_at", first_done(), 50);
    check_eq("snap_done_count", done_count(), 1);
    idle_cycles(3);

    // Asynchronous reset in the middle of TONE_ON
    play(4, -1, -1, -1, '0);
    check_eq("arst_tone_before", tr_tone[3], 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_tone", tone, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_slot", slot_idx, 15);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(6);
    check_eq("arst_idle_busy", busy, 0);
    check_eq("arst_idle_tone", tone, 0);
    play(8, -1, -1, -1, '0);
    check_eq("arst_restart_tone", first_tone(0, 1'b1), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
